expr_gen: RTL and testbench
===========================

# expr_gen

Expression stream generator: the transmit side of the ASCII expression character interface consumed by the `expr` checker. On a start pulse it serialises one expression of the form digit (op digit)* as one 8-bit ASCII character per accepted cycle. Digits and operators come from an internal LFSR. An optional error-injection mode appends a trailing operator, so benches and on-board self-test can drive the checker with known-good and known-bad streams.

## Interface
Parameters:
- `N_W`, default 3: width of `len`; the operand count is `len`+1 (1..2^N_W).

Ports:
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `clr`, in, 1: asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `start`, in, 1: request a new expression; sampled only in IDLE.
- `len`, in, N_W: number of operators; sampled with `start`.
- `seed`, in, 8: LFSR seed; sampled with `start`. Seed 8'h00 is replaced by 8'h01.
- `bad`, in, 1: error injection; sampled with `start`. When 1, one extra operator follows the last digit.
- `ready`, in, 1: downstream accepts the character this cycle.
- `out`, out, 8: ASCII character. Digits are 8'h30..8'h39, '+' is 8'h2B, '*' is 8'h2A, and the idle value is 8'h00.
- `valid`, out, 1: `out` holds a character.
- `busy`, out, 1: an expression is in progress; high from the cycle after `start` through the DONE cycle.
- `done`, out, 1: single-cycle pulse after the last character is accepted.

## Operation
- States: IDLE, DIGIT, OP, TAIL, DONE.
- IDLE with `start`=1:
  - latch `len` into the operator counter, latch `bad`, load `lfsr` with `seed` (8'h01 if zero);
  - go to DIGIT.
- `start` is ignored in every state except IDLE.
- DIGIT: `out` = 8'h30 + d, where n = `lfsr[3:0]` and d = n if n<10, else n-10.
- OP and TAIL: `out` = `lfsr[4]` ? 8'h2A : 8'h2B.
- `valid`=1 in DIGIT, OP and TAIL. Otherwise `valid`=0 and `out`=8'h00.
- Accept means `valid` & `ready`. On accept:
  - `lfsr` <= {`lfsr[6:0]`, `lfsr[7]`^`lfsr[5]`^`lfsr[4]`^`lfsr[3]`};
  - the state advances.
- When `ready`=0, `out`, `lfsr`, the state and the counters hold unchanged.
- Transitions on accept:
  - DIGIT with counter≠0 -> OP.
  - DIGIT with counter=0 -> TAIL if `bad` was latched, else DONE.
  - OP -> DIGIT, decrementing the counter.
  - TAIL -> DONE.
- DONE: `done`=1 and `busy`=1 for exactly one cycle, then IDLE unconditionally.
- A valid expression has 2·`len`+1 characters. With `bad` it has 2·`len`+2.
- The counter never wraps. `len` = 2^N_W-1 gives the maximum of 2^N_W operands.
- `clr`=0 at any time, including mid-expression:
  - immediately forces IDLE, `out`=8'h00, `valid`=0, `busy`=0, `done`=0, `lfsr`=8'h01, counter=0;
  - the partial expression is abandoned and is not resumed.

## Timing
- Reset values: `out`=8'h00, `valid`=0, `busy`=0, `done`=0.
- `start` is sampled at edge T. The first character is valid after T, i.e. during cycle T+1.
- With `ready` held at 1, one character is emitted per cycle. `done` is high in the cycle after the last accept.
- The next `start` is accepted in the IDLE cycle following DONE at the earliest. Back-to-back spacing is therefore 2 cycles between expressions.
- `out` and `valid` are registered, with no combinational path from `ready` to `out`.
- Deasserting `clr` between edges takes effect at the next rising edge. `start` high on that same edge is honoured.

## Test plan
- `seed`=8'h01, `len`=1, `bad`=0, `ready`=1: `out` = "1","+","4" on 3 consecutive cycles, then `done`=1 for 1 cycle, then `valid`=0 and `out`=8'h00.
- Same inputs with `bad`=1: `out` = "1","+","4","+" then `done`. Feeding the checker gives out=1 after "1" and after "4", and out=0 after the final "+".
- `seed`=8'h00, `len`=0: identical to seed 8'h01, i.e. the single character "1". Also `seed`=8'h1F, `len`=0: the single character "5" (n=15 -> 5).
- Stall: `seed`=8'h01, `len`=1, `ready`=0 for 3 cycles after the first character. `out` stays "1" with `valid`=1 and the sequence continues "+","4" unchanged. Also `start` pulsed while `busy` has no effect.
- Reset mid-operation: `clr` is driven low between edges while "+" is on `out`. `out`=8'h00, `valid`=0 and `busy`=0 follow immediately. After release, a new `start` with `seed`=8'h01, `len`=0 emits "1".
- Max length, `len`=7 (`N_W`=3), `ready`=1: exactly 15 characters alternating digit/operator, beginning and ending with a digit, and `done` in cycle 16 after `start`.

Source files
------------

// File: rtl/expr_gen_if.sv
// expr_gen_if: character-stream bus between the expression generator and its
// consumer.
//   start/len/seed/bad : request a new expression (driven by the requester)
//   ready              : consumer accepts the current character
//   out/valid          : ASCII character and its qualifier (driven by expr_gen)
//   busy/done          : expression in progress / one-cycle completion pulse
//
// Handshake: a character transfers on a rising edge where valid and ready are
// both high. While valid is high and ready is low, out is held stable. valid
// never depends on ready within the same cycle.
interface expr_gen_if #(
    parameter int N_W = 3
) ();
    logic           start;
    logic [N_W-1:0] len;
    logic [7:0]     seed;
    logic           bad;
    logic           ready;
    logic [7:0]     out;
    logic           valid;
    logic           busy;
    logic           done;

    modport master (
        input  start, len, seed, bad, ready,
        output out, valid, busy, done
    );

    modport slave (
        output start, len, seed, bad, ready,
        input  out, valid, busy, done
    );
endinterface

// File: rtl/expr_gen.sv
// expr_gen: serialises one ASCII expression "digit (op digit)*" per start
// request, one character per accepted cycle, with optional trailing-operator
// error injection.
//   clk       : rising-edge clock
//   clr       : asynchronous active-low reset
//   bus       : expr_gen_if master modport (request, character stream, status)
//   dbg_state : current FSM state encoding, for observation only
module expr_gen #(
    parameter int N_W = 3
) (
    input  logic        clk,
    input  logic        clr,
    expr_gen_if.master  bus,
    output logic [2:0]  dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DIGIT = 3'd1,
        S_OP    = 3'd2,
        S_TAIL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     lfsr_q,  lfsr_d;
    logic [N_W-1:0] cnt_q,   cnt_d;
    logic           bad_q,   bad_d;
    logic [7:0]     out_q,   out_d;
    logic           valid_q, valid_d;
    logic           busy_q,  busy_d;
    logic           done_q,  done_d;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Character shown while sitting in state s with LFSR value v. Nibbles
    // 10..15 fold back onto digits 0..5.
    function automatic logic [7:0] char_for(input state_t s, input logic [7:0] v);
        logic [3:0] n;
        logic [3:0] d;
        n = v[3:0];
        d = (n < 4'd10) ? n : (n - 4'd10);
        case (s)
            S_DIGIT:      return 8'h30 + {4'h0, d};
            S_OP, S_TAIL: return v[4] ? 8'h2A : 8'h2B;
            default:      return 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cnt_d   = bus.len;
                    bad_d   = bus.bad;
                    lfsr_d  = (bus.seed == 8'h00) ? 8'h01 : bus.seed;
                    state_d = S_DIGIT;
                end
            end
            S_DIGIT: begin
                if (bus.ready) begin
                    lfsr_d = lfsr_step(lfsr_q);
                    if (cnt_q != '0) state_d = S_OP;
                    else if (bad_q)  state_d = S_TAIL;
                    else             state_d = S_DONE;
                end
            end
            S_OP: begin
                if (bus.ready) begin
                    lfsr_d  = lfsr_step(lfsr_q);
                    cnt_d   = cnt_q - N_W'(1);
                    state_d = S_DIGIT;
                end
            end
            S_TAIL: begin
                if (bus.ready) begin
                    lfsr_d  = lfsr_step(lfsr_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are computed from the next state and registered, so out and
        // valid carry no combinational path from ready.
        out_d   = char_for(state_d, lfsr_d);
        valid_d = (state_d == S_DIGIT) || (state_d == S_OP) || (state_d == S_TAIL);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            lfsr_q  <= 8'h01;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            out_q   <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_expr_gen.sv
// tb_expr_gen: scoreboard bench for expr_gen. Expected characters are queued
// when an expression is requested and popped by a monitor on every accepted
// transfer.
module tb_expr_gen;
    localparam int N_W = 3;

    logic       clk;
    logic       clr;
    logic [2:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;

    logic [7:0] exp_q[$];

    expr_gen_if #(.N_W(N_W)) bus ();

    expr_gen #(.N_W(N_W)) dut (
        .clk       (clk),
        .clr       (clr),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h required=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (clr && bus.valid && bus.ready) begin
            acc_cnt++;
            if (exp_q.size() == 0) chk("extra_char", {24'h0, bus.out}, 32'hFFFF_FFFF);
            else                   chk("char", {24'h0, bus.out}, {24'h0, exp_q.pop_front()});
        end
    end

    // ---------------- reference model ----------------
    task automatic push_model(input logic [7:0] s, input int l, input bit b);
        logic [7:0] v;
        logic [3:0] n;
        v = (s == 8'h00) ? 8'h01 : s;
        for (int i = 0; i <= l; i++) begin
            n = v[3:0];
            exp_q.push_back(8'h30 + ((n < 4'd10) ? {4'h0, n} : {4'h0, n - 4'd10}));
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
            if (i < l) begin
                exp_q.push_back(v[4] ? 8'h2A : 8'h2B);
                v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
            end
        end
        if (b) exp_q.push_back(v[4] ? 8'h2A : 8'h2B);
    endtask

    // ---------------- drivers ----------------
    // Returns #1 into the first cycle after the sampling edge.
    task automatic start_expr(input logic [7:0] s, input logic [N_W-1:0] l, input bit b);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.seed  = s;
        bus.len   = l;
        bus.bad   = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Counts cycles since the start edge until done; exp_cyc<0 skips the
    // latency check. Optionally randomises ready each cycle.
    task automatic wait_done(input string tag, input int exp_cyc, input bit rnd);
        int n;
        bit seen;
        n = 1;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (rnd) bus.ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        bus.ready = 1'b1;
        chk({tag, "_done_seen"}, {31'h0, seen}, 32'h1);
        if (seen) begin
            if (exp_cyc >= 0) chk({tag, "_done_cycle"}, n, exp_cyc);
            chk({tag, "_busy_in_done"}, {31'h0, bus.busy}, 32'h1);
            chk({tag, "_queue_empty"}, exp_q.size(), 0);
            @(posedge clk); #1;
            chk({tag, "_done_pulse"}, {31'h0, bus.done}, 32'h0);
            chk({tag, "_idle_valid"}, {31'h0, bus.valid}, 32'h0);
            chk({tag, "_idle_out"}, {24'h0, bus.out}, 32'h0);
            chk({tag, "_idle_busy"}, {31'h0, bus.busy}, 32'h0);
        end
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clr       = 1'b0;
        bus.start = 1'b0;
        bus.len   = '0;
        bus.seed  = 8'h00;
        bus.bad   = 1'b0;
        bus.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out",   {24'h0, bus.out}, 32'h0);
        chk("rst_valid", {31'h0, bus.valid}, 32'h0);
        chk("rst_busy",  {31'h0, bus.busy}, 32'h0);
        chk("rst_done",  {31'h0, bus.done}, 32'h0);
        clr = 1'b1;

        // "1+4"
        exp_q.push_back(8'h31); exp_q.push_back(8'h2B); exp_q.push_back(8'h34);
        start_expr(8'h01, 3'd1, 1'b0);
        chk("basic_first_valid", {31'h0, bus.valid}, 32'h1);
        wait_done("basic", 4, 1'b0);

        // "1+4+" with error injection
        exp_q.push_back(8'h31); exp_q.push_back(8'h2B);
        exp_q.push_back(8'h34); exp_q.push_back(8'h2B);
        start_expr(8'h01, 3'd1, 1'b1);
        wait_done("bad", 5, 1'b0);

        // zero seed behaves as seed 1
        exp_q.push_back(8'h31);
        start_expr(8'h00, 3'd0, 1'b0);
        wait_done("seed0", 2, 1'b0);

        // nibble 15 folds to '5'
        exp_q.push_back(8'h35);
        start_expr(8'h1F, 3'd0, 1'b0);
        wait_done("seed1f", 2, 1'b0);

        // stall on first character, with an ignored start while busy
        exp_q.push_back(8'h31); exp_q.push_back(8'h2B); exp_q.push_back(8'h34);
        start_expr(8'h01, 3'd1, 1'b0);
        bus.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_out",   {24'h0, bus.out}, 32'h31);
            chk("stall_valid", {31'h0, bus.valid}, 32'h1);
            bus.start = (i == 1);
            bus.seed  = 8'h1F;
            bus.len   = 3'd0;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.ready = 1'b1;
        wait_done("stall", -1, 1'b0);

        // reset while '+' is on the bus
        exp_q.push_back(8'h31); exp_q.push_back(8'h2B); exp_q.push_back(8'h34);
        start_expr(8'h01, 3'd1, 1'b0);
        @(posedge clk); #1;
        chk("midrst_pre_out", {24'h0, bus.out}, 32'h2B);
        @(negedge clk); #2;
        clr = 1'b0;
        #1;
        chk("midrst_out",   {24'h0, bus.out}, 32'h0);
        chk("midrst_valid", {31'h0, bus.valid}, 32'h0);
        chk("midrst_busy",  {31'h0, bus.busy}, 32'h0);
        exp_q.delete();
        #1;
        clr = 1'b1;
        exp_q.push_back(8'h31);
        start_expr(8'h01, 3'd0, 1'b0);
        wait_done("after_rst", 2, 1'b0);

        // maximum length
        push_model(8'h01, 7, 1'b0);
        acc_cnt = 0;
        start_expr(8'h01, 3'd7, 1'b0);
        wait_done("maxlen", 16, 1'b0);
        chk("maxlen_chars", acc_cnt, 15);

        // random expressions with random backpressure
        for (int t = 0; t < 6; t++) begin
            logic [7:0] s;
            int l;
            bit b;
            s = 8'($urandom_range(0, 255));
            l = $urandom_range(0, 7);
            b = 1'($urandom_range(0, 1));
            push_model(s, l, b);
            acc_cnt = 0;
            start_expr(s, 3'(l), b);
            wait_done("rand", -1, 1'b1);
            chk("rand_chars", acc_cnt, 2 * l + 1 + int'(b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
